// File: rtl/collision_pkg.sv
// Shared types and constants for the collision scanner: tile positions, scan FSM states and
// the fixed probe slots used by the game top level.
package collision_pkg;

    localparam int unsigned POS_W_DEFAULT = 8;

    // Tile position as laid out on the bus: xxxx_yyyy.
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } tile_pos_t;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StReport
    } scan_state_e;

    localparam int unsigned PROBE_PLAYER = 0;
    localparam int unsigned PROBE_SWORD  = 1;
    localparam int unsigned PROBE_SHEEP  = 2;

endpackage

// File: rtl/collision_probe_cmp.sv
// Compares a single probe tile against the segment currently being scanned.
module collision_probe_cmp
    import collision_pkg::*;
#(
    parameter int unsigned POS_W = POS_W_DEFAULT
) (
    input  logic [POS_W-1:0] probe_pos,
    input  logic             probe_en,
    input  logic [POS_W-1:0] seg_pos,
    input  logic             seg_en,
    output logic             hit
);

    assign hit = probe_en & seg_en & (probe_pos == seg_pos);

endmodule

// File: rtl/collision_scanner.sv
// Serial probe-vs-dragon-segment collision scanner: one segment per clock, all probes in parallel.
// Optional rise-pulse cooldown enabled by defining COLLISION_SCANNER_COOLDOWN_EN.
module collision_scanner
    import collision_pkg::*;
#(
    parameter int unsigned NUM_PROBES      = 3,
    parameter int unsigned NUM_SEGMENTS    = 7,
    parameter int unsigned POS_W           = POS_W_DEFAULT,
    parameter int unsigned IDX_W           = 3
`ifdef COLLISION_SCANNER_COOLDOWN_EN
    ,
    parameter int unsigned COOLDOWN_FRAMES = 30
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_PROBES*POS_W-1:0]   probe_pos,
    input  logic [NUM_PROBES-1:0]         probe_en,
    input  logic [NUM_SEGMENTS*POS_W-1:0] seg_pos,
    input  logic [NUM_SEGMENTS-1:0]       seg_en,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_PROBES-1:0]         hit_level,
    output logic [NUM_PROBES-1:0]         hit_rise,
    output logic [NUM_PROBES*IDX_W-1:0]   hit_idx,
    output logic                          overrun
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_SEGMENTS - 1);

    scan_state_e state_q, state_d;

    logic [NUM_PROBES*POS_W-1:0]   probe_pos_q;
    logic [NUM_PROBES-1:0]         probe_en_q;
    logic [NUM_SEGMENTS*POS_W-1:0] seg_pos_q;
    logic [NUM_SEGMENTS-1:0]       seg_en_q;
    logic [IDX_W-1:0]              idx_q;
    logic [NUM_PROBES-1:0]         acc_q;
    logic [NUM_PROBES*IDX_W-1:0]   idx_acc_q;
    logic [NUM_PROBES-1:0]         hit_level_q;
    logic [NUM_PROBES-1:0]         hit_rise_q;
    logic [NUM_PROBES*IDX_W-1:0]   hit_idx_q;
    logic                          done_q;
    logic                          overrun_q;

    logic [POS_W-1:0]      cur_seg_pos;
    logic                  cur_seg_en;
    logic [NUM_PROBES-1:0] hit;
    logic [NUM_PROBES-1:0] rise_commit;

    assign cur_seg_pos = seg_pos_q[idx_q*POS_W +: POS_W];
    assign cur_seg_en  = seg_en_q[idx_q];

    for (genvar p = 0; p < NUM_PROBES; p++) begin : g_probe
        collision_probe_cmp #(
            .POS_W(POS_W)
        ) u_cmp (
            .probe_pos(probe_pos_q[p*POS_W +: POS_W]),
            .probe_en (probe_en_q[p]),
            .seg_pos  (cur_seg_pos),
            .seg_en   (cur_seg_en),
            .hit      (hit[p])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StScan;
            StScan:   if (idx_q == LastIdx) state_d = StReport;
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
    end

`ifdef COLLISION_SCANNER_COOLDOWN_EN
    localparam int unsigned CntW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    logic [NUM_PROBES-1:0][CntW-1:0] cd_cnt_q;
    logic [NUM_PROBES-1:0]           cd_active;

    always_comb begin
        cd_active = '0;
        for (int p = 0; p < NUM_PROBES; p++) cd_active[p] = (cd_cnt_q[p] != '0);
    end

    assign rise_commit = acc_q & ~hit_level_q & ~cd_active;

    // Counters only move on commit, so they count frames rather than clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_cnt_q <= '0;
        end else if (state_q == StReport) begin
            for (int p = 0; p < NUM_PROBES; p++) begin
                if (cd_active[p]) begin
                    cd_cnt_q[p] <= cd_cnt_q[p] - 1'b1;
                end else if (rise_commit[p]) begin
                    cd_cnt_q[p] <= CntW'(COOLDOWN_FRAMES);
                end
            end
        end
    end
`else
    assign rise_commit = acc_q & ~hit_level_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_pos_q <= '0;
            probe_en_q  <= '0;
            seg_pos_q   <= '0;
            seg_en_q    <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            idx_acc_q   <= '0;
            hit_level_q <= '0;
            hit_rise_q  <= '0;
            hit_idx_q   <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            hit_rise_q <= '0;
            if (start && state_q != StIdle) overrun_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        probe_pos_q <= probe_pos;
                        probe_en_q  <= probe_en;
                        seg_pos_q   <= seg_pos;
                        seg_en_q    <= seg_en;
                        acc_q       <= '0;
                        idx_acc_q   <= '0;
                        idx_q       <= '0;
                    end
                end
                StScan: begin
                    acc_q <= acc_q | hit;
                    // Lowest index wins: only the first hit per probe is recorded.
                    for (int p = 0; p < NUM_PROBES; p++) begin
                        if (hit[p] && !acc_q[p]) idx_acc_q[p*IDX_W +: IDX_W] <= idx_q;
                    end
                    if (idx_q != LastIdx) idx_q <= idx_q + 1'b1;
                end
                StReport: begin
                    hit_level_q <= acc_q;
                    hit_rise_q  <= rise_commit;
                    hit_idx_q   <= idx_acc_q;
                    done_q      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done      = done_q;
    assign hit_level = hit_level_q;
    assign hit_rise  = hit_rise_q;
    assign hit_idx   = hit_idx_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed, table-driven bench for collision_scanner at default parameters.
module tb_collision_scanner;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] probe_pos;
    logic [2:0]  probe_en;
    logic [55:0] seg_pos;
    logic [6:0]  seg_en;
    logic        busy;
    logic        done;
    logic [2:0]  hit_level;
    logic [2:0]  hit_rise;
    logic [8:0]  hit_idx;
    logic        overrun;

    collision_scanner dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .probe_pos(probe_pos),
        .probe_en (probe_en),
        .seg_pos  (seg_pos),
        .seg_en   (seg_en),
        .busy     (busy),
        .done     (done),
        .hit_level(hit_level),
        .hit_rise (hit_rise),
        .hit_idx  (hit_idx),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][7:0] pp;
        logic [2:0]      pe;
        logic [6:0][7:0] sp;
        logic [6:0]      se;
        logic [2:0]      lvl;
        logic [2:0]      rise;
        logic [8:0]      idx;
    } vec_t;

    vec_t vecs [8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one frame scan for a fixed window; captures outputs in the first done cycle.
    task automatic do_scan(input int tweak_at, input int restart_at, output int lat,
                           output int ndone, output logic [2:0] lvl, output logic [2:0] rise,
                           output logic [8:0] idx, output logic busy_at_done);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        ndone = 0;
        lvl = 'x;
        rise = 'x;
        idx = 'x;
        busy_at_done = 1'bx;
        for (int c = 1; c <= 20; c++) begin
            if (c == tweak_at) begin
                probe_pos = '0;
                probe_en  = '0;
                seg_en    = '0;
            end
            start = (c == restart_at);
            tick();
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c;
                    lvl = hit_level;
                    rise = hit_rise;
                    idx = hit_idx;
                    busy_at_done = busy;
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        vec_t v;
        int lat, ndone;
        logic [2:0] lvl, rise;
        logic [8:0] idx;
        logic bsy;

        v = '0;
        for (int s = 0; s < 7; s++) v.sp[s] = 8'h80 + 8'(s);
        v.se = 7'h7f;
        v.pp[0] = 8'h35; v.pp[1] = 8'h44; v.pp[2] = 8'h55;
        // Player hits seg2 only.
        v.pe = 3'b001; v.sp[2] = 8'h35;
        v.lvl = 3'b001; v.rise = 3'b001; v.idx = 9'h002; vecs[0] = v;
        // Same frame again: level held, no new rise.
        v.rise = 3'b000; vecs[1] = v;
        // Sword on seg0 but seg0 disabled; player level falls silently.
        v.pe = 3'b010; v.sp[0] = 8'h44; v.se = 7'h7e;
        v.lvl = 3'b000; v.rise = 3'b000; v.idx = 9'h000; vecs[2] = v;
        v.se = 7'h7f;
        v.lvl = 3'b010; v.rise = 3'b010; v.idx = 9'h000; vecs[3] = v;
        // Sheep overlaps seg1 and seg5: lowest index reported.
        v.pe = 3'b100; v.sp[1] = 8'h55; v.sp[5] = 8'h55;
        v.lvl = 3'b100; v.rise = 3'b100; v.idx = 9'h040; vecs[4] = v;
        // All probes hit; player also matches seg6.
        v.pe = 3'b111; v.sp[6] = 8'h35;
        v.lvl = 3'b111; v.rise = 3'b011; v.idx = 9'h042; vecs[5] = v;
        // Near-miss positions need full equality; seg1 disabled moves sheep to seg5.
        v.pp[0] = 8'h53; v.pp[1] = 8'h45; v.se = 7'h7d;
        v.lvl = 3'b100; v.rise = 3'b000; v.idx = 9'h140; vecs[6] = v;
        // Last segment index.
        v.pp[0] = 8'h77; v.pe = 3'b001; v.sp[6] = 8'h77; v.se = 7'h7f;
        v.lvl = 3'b001; v.rise = 3'b001; v.idx = 9'h006; vecs[7] = v;

        rst_n = 1'b0;
        start = 1'b0;
        probe_pos = '0;
        probe_en = '0;
        seg_pos = '0;
        seg_en = '0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_level", hit_level, 0);
        check("reset_idx", hit_idx, 0);
        check("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            probe_pos = vecs[i].pp;
            probe_en  = vecs[i].pe;
            seg_pos   = vecs[i].sp;
            seg_en    = vecs[i].se;
            do_scan(0, 0, lat, ndone, lvl, rise, idx, bsy);
            check($sformatf("v%0d_latency", i), lat, 8);
            check($sformatf("v%0d_level", i), lvl, vecs[i].lvl);
            check($sformatf("v%0d_rise", i), rise, vecs[i].rise);
            check($sformatf("v%0d_idx", i), idx, vecs[i].idx);
        end
        check("busy_at_done", bsy, 0);
        check("rise_cleared", hit_rise, 0);
        check("done_cleared", done, 0);

        // Inputs wiped at scan cycle 3 must not affect the result.
        probe_pos = vecs[7].pp;
        probe_pos[15:8] = 8'h44;
        probe_en = 3'b010;
        seg_pos = vecs[7].sp;
        seg_en = 7'h7f;
        do_scan(3, 0, lat, ndone, lvl, rise, idx, bsy);
        check("snap_level", lvl, 3'b010);
        check("snap_rise", rise, 3'b010);
        check("snap_idx", idx, 9'h000);

        // Second start mid-scan is dropped and flagged.
        check("overrun_pre", overrun, 0);
        probe_pos = {8'h55, 8'h44, 8'h77};
        probe_en = 3'b111;
        seg_pos = vecs[7].sp;
        seg_en = 7'h7f;
        do_scan(0, 4, lat, ndone, lvl, rise, idx, bsy);
        check("ovr_latency", lat, 8);
        check("ovr_ndone", ndone, 1);
        check("ovr_level", lvl, 3'b111);
        check("ovr_rise", rise, 3'b101);
        check("ovr_idx", idx, 9'h046);
        check("overrun_set", overrun, 1);
        do_scan(0, 0, lat, ndone, lvl, rise, idx, bsy);
        check("after_ovr_latency", lat, 8);
        check("after_ovr_ndone", ndone, 1);
        check("after_ovr_rise", rise, 3'b000);
        check("overrun_sticky", overrun, 1);

        // Asynchronous reset during scan cycle 5.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_scan", busy, 1);
        for (int c = 0; c < 4; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_level", hit_level, 0);
        check("arst_idx", hit_idx, 0);
        check("arst_overrun", overrun, 0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) ndone++;
        end
        check("arst_no_done", ndone, 0);
        check("arst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
